// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated four-approach junction sequencer.
// Cycles ALLRED -> GREEN -> YELLOW -> ALLRED. The next approach to serve is chosen
// round-robin from latched vehicle demand. Intervals are counted in tick cycles.
// Optional emergency preemption is compiled in when EMERG_PREEMPT_EN is defined.
module traffic_phase_scheduler #(
    parameter int unsigned TIMER_W   = 8,
    parameter int unsigned MIN_GREEN = 10,
    parameter int unsigned MAX_GREEN = 30,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] req,
`ifdef EMERG_PREEMPT_EN
    input  logic       emerg_req,
    input  logic [1:0] emerg_phase,
`endif
    output logic [3:0] green,
    output logic [3:0] yellow,
    output logic [3:0] red,
    output logic [1:0] phase,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        StAllRed = 2'd0,
        StGreen  = 2'd1,
        StYellow = 2'd2
    } state_t;

    // Interval end points, expressed as the timer value on the final tick.
    localparam logic [TIMER_W-1:0] MIN_M1    = TIMER_W'(MIN_GREEN - 1);
    localparam logic [TIMER_W-1:0] MAX_M1    = TIMER_W'(MAX_GREEN - 1);
    localparam logic [TIMER_W-1:0] YEL_M1    = TIMER_W'(YELLOW_T - 1);
    localparam logic [TIMER_W-1:0] AR_M1     = TIMER_W'(ALLRED_T - 1);
    localparam logic [TIMER_W-1:0] AR_FULL   = TIMER_W'(ALLRED_T);

    state_t             state_q, state_d;
    logic [1:0]         phase_q, phase_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [3:0]         pending_q, pending_d;
    logic [3:0]         green_q, green_d;
    logic [3:0]         yellow_q, yellow_d;
    logic [3:0]         red_q, red_d;

    logic [3:0] phase_onehot;
    logic       other_pend;
    logic       any_pend;
    logic       allred_done;
    logic       green_release;
    logic       rr_found;
    logic [1:0] rr_phase;
    logic [1:0] rr_cand;

    assign phase_onehot = 4'b0001 << phase_q;
    assign other_pend   = |(pending_q & ~phase_onehot);
    assign any_pend     = |pending_q;

    // All-red clearance satisfied now, or already satisfied on an earlier tick.
    assign allred_done = (tick && (timer_q == AR_M1)) || (timer_q >= AR_FULL);

    // A tick at or past the minimum green ends the phase; the maximum-green tick is
    // always at or past the minimum, so it is included for completeness only.
    assign green_release = tick && ((timer_q >= MIN_M1) || (timer_q == MAX_M1));

    // Round-robin search: phase+1, phase+2, phase+3, then phase itself.
    always_comb begin
        rr_found = 1'b0;
        rr_phase = phase_q;
        rr_cand  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            rr_cand = phase_q + 2'(k);
            if (!rr_found && pending_q[rr_cand]) begin
                rr_found = 1'b1;
                rr_phase = rr_cand;
            end
        end
    end

    // Next state and phase selection.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            StAllRed: begin
                if (allred_done) begin
`ifdef EMERG_PREEMPT_EN
                    if (emerg_req) begin
                        state_d = StGreen;
                        phase_d = emerg_phase;
                    end else
`endif
                    if (any_pend) begin
                        state_d = StGreen;
                        phase_d = rr_phase;
                    end
                end
            end
            StGreen: begin
`ifdef EMERG_PREEMPT_EN
                if (emerg_req) begin
                    if (phase_q != emerg_phase) begin
                        state_d = StYellow;
                    end
                end else
`endif
                if (other_pend && green_release) begin
                    state_d = StYellow;
                end
            end
            StYellow: begin
                if (tick && (timer_q == YEL_M1)) begin
                    state_d = StAllRed;
                end
            end
            default: state_d = StAllRed;
        endcase
    end

    // Demand latch, interval timer and registered lamp values.
    always_comb begin
        pending_d = pending_q | (req & ~((state_q == StGreen) ? phase_onehot : 4'b0000));
        if ((state_d == StGreen) && (state_q != StGreen)) begin
            pending_d = pending_d & ~(4'b0001 << phase_d);
        end

        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (tick && (timer_q != '1)) begin
            timer_d = timer_q + 1'b1;
        end

        green_d  = (state_d == StGreen)  ? (4'b0001 << phase_d) : 4'b0000;
        yellow_d = (state_d == StYellow) ? (4'b0001 << phase_d) : 4'b0000;
        red_d    = ~(green_d | yellow_d);
    end

    // State and output registers; reset aborts any interval immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StAllRed;
            phase_q   <= 2'd3;
            timer_q   <= '0;
            pending_q <= 4'b0000;
            green_q   <= 4'b0000;
            yellow_q  <= 4'b0000;
            red_q     <= 4'b1111;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            green_q   <= green_d;
            yellow_q  <= yellow_d;
            red_q     <= red_d;
        end
    end

    assign green  = green_q;
    assign yellow = yellow_q;
    assign red    = red_q;
    assign phase  = phase_q;
    assign state  = state_q;

endmodule
